// File: rtl/timer_cnt_cmp.sv
// Prescaled up/down timer counter with word-writable counter/compare registers and sticky match flags.
// Optional macro TMR_AUTORELOAD_EN: counter reloads from cmp[0] instead of free-running wrap.

module tmr_cmp_ch #(
    parameter int CNT_W  = 64,
    parameter int DATA_W = 32,
    parameter int NW     = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [NW-1:0]     wr_word,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              step,
    input  logic [CNT_W-1:0]  cnt_next,
    input  logic              flag_clr,
    output logic [CNT_W-1:0]  cmp,
    output logic              flag
);
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmp  <= '1;
            flag <= 1'b0;
        end else begin
            for (int k = 0; k < NW; k++)
                if (wr_word[k]) cmp[k*DATA_W +: DATA_W] <= wr_data;
            // a match in the same cycle as a clear keeps the flag set
            if (step && cnt_next == cmp) flag <= 1'b1;
            else if (flag_clr)           flag <= 1'b0;
        end
    end
endmodule

module timer_cnt_cmp #(
    parameter int CNT_W   = 64,
    parameter int DATA_W  = 32,
    parameter int NUM_CMP = 2,
    parameter int IDX_W   = 5
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     cnt_en,
    input  logic                     cnt_clr,
    input  logic                     cnt_dir,
    input  logic                     div_en,
    input  logic [7:0]               div_val,
    input  logic                     halt_req,
    output logic                     halt_ack,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_CMP-1:0]       int_mask,
    input  logic [NUM_CMP-1:0]       int_clr,
    output logic [CNT_W-1:0]         cnt,
    output logic [NUM_CMP*CNT_W-1:0] cmp_flat,
    output logic [NUM_CMP-1:0]       int_flag,
    output logic                     ovf_flag,
    output logic                     irq
);
    localparam int NW = CNT_W / DATA_W;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [NUM_CMP-1:0][CNT_W-1:0] cmp_q;
    logic [7:0]       div_cnt;
    logic             active, tick, cnt_wr, step, wrap, reload;
    logic [CNT_W-1:0] cnt_step;

    always_comb begin
        active = cnt_en & ~halt_ack;
        tick   = div_en ? (active && div_cnt == div_val) : active;
        cnt_wr = wr_en && (wr_idx < IDX_W'(NW));
        step   = tick & ~cnt_clr & ~cnt_wr;
`ifdef TMR_AUTORELOAD_EN
        reload = cnt_dir ? (cnt == '0) : (cnt == cmp_q[0]);
`else
        reload = 1'b0;
`endif
        wrap     = 1'b0;
        cnt_step = cnt;
        if (reload) begin
            cnt_step = cnt_dir ? cmp_q[0] : '0;
        end else if (cnt_dir) begin
            cnt_step = cnt - ONE;
            wrap     = (cnt == '0);
        end else begin
            cnt_step = cnt + ONE;
            wrap     = &cnt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            halt_ack <= 1'b0;
            div_cnt  <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
        end else begin
            halt_ack <= halt_req;

            if (cnt_clr || !cnt_en)   div_cnt <= '0;
            else if (halt_ack)        div_cnt <= div_cnt;
            else if (!div_en || tick) div_cnt <= '0;
            else                      div_cnt <= div_cnt + 8'd1;

            if (cnt_clr) begin
                cnt      <= '0;
                ovf_flag <= 1'b0;
            end else if (cnt_wr) begin
                for (int k = 0; k < NW; k++)
                    if (wr_idx == IDX_W'(k)) cnt[k*DATA_W +: DATA_W] <= wr_data;
            end else if (step) begin
                cnt <= cnt_step;
                if (wrap) ovf_flag <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CMP; i++) begin : g_ch
        logic [NW-1:0] wr_word;
        for (genvar k = 0; k < NW; k++) begin : g_w
            assign wr_word[k] = wr_en && (wr_idx == IDX_W'(NW*(1+i)+k));
        end
        tmr_cmp_ch #(.CNT_W(CNT_W), .DATA_W(DATA_W), .NW(NW)) u_ch (
            .sys_clk  (sys_clk),
            .sys_rst_n(sys_rst_n),
            .wr_word  (wr_word),
            .wr_data  (wr_data),
            .step     (step),
            .cnt_next (cnt_step),
            .flag_clr (int_clr[i]),
            .cmp      (cmp_q[i]),
            .flag     (int_flag[i])
        );
    end

    assign cmp_flat = cmp_q;
    assign irq      = |(int_flag & int_mask);
endmodule

// File: tb/tb_timer_cnt_cmp.sv
// Directed bench for timer_cnt_cmp (default 64-bit counter, 32-bit words, two compare channels).

module tb_timer_cnt_cmp;
    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic         cnt_en, cnt_clr, cnt_dir, div_en;
    logic [7:0]   div_val;
    logic         halt_req, halt_ack;
    logic         wr_en;
    logic [4:0]   wr_idx;
    logic [31:0]  wr_data;
    logic [1:0]   int_mask, int_clr;
    logic [63:0]  cnt;
    logic [127:0] cmp_flat;
    logic [1:0]   int_flag;
    logic         ovf_flag, irq;

    int n_chk  = 0;
    int n_pass = 0;

    timer_cnt_cmp #(.CNT_W(64), .DATA_W(32), .NUM_CMP(2), .IDX_W(5)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .cnt_dir(cnt_dir), .div_en(div_en), .div_val(div_val), .halt_req(halt_req),
        .halt_ack(halt_ack), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .int_mask(int_mask), .int_clr(int_clr), .cnt(cnt), .cmp_flat(cmp_flat),
        .int_flag(int_flag), .ovf_flag(ovf_flag), .irq(irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        wr_en = 1'b1; wr_idx = idx; wr_data = data;
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
    endtask

    logic [63:0] exp_seq [6];

    initial begin
        sys_rst_n = 1'b0; cnt_en = 0; cnt_clr = 0; cnt_dir = 0; div_en = 0; div_val = 0;
        halt_req = 0; wr_en = 0; wr_idx = 0; wr_data = 0; int_mask = 0; int_clr = 0;
        cyc(2);
        sys_rst_n = 1'b1;

        // reset mid-count
        cnt_en = 1'b1;
        cyc(5);
        chk("cnt_before_rst", cnt, 64'd5);
        #2 sys_rst_n = 1'b0;
        #1 chk("async_rst_cnt", cnt, 64'd0);
        cnt_en = 1'b0;
        cyc(1);
        sys_rst_n = 1'b1;
        cyc(1);
        chk("rst_cnt", cnt, 64'd0);
        chk("rst_cmp", cmp_flat, {128{1'b1}});
        chk("rst_flags", {int_flag, ovf_flag, irq, halt_ack}, 5'd0);

        // up wrap from all-ones
        wr(5'd0, 32'hFFFF_FFFF);
        wr(5'd1, 32'hFFFF_FFFF);
        chk("wr_cnt_ones", cnt, {64{1'b1}});
        chk("wr_no_match", int_flag, 2'b00);
        cnt_en = 1'b1; cyc(1); cnt_en = 1'b0;
        chk("up_wrap_cnt", cnt, 64'd0);
        chk("up_wrap_ovf", ovf_flag, 1'b1);
        clr();
        chk("clr_ovf", ovf_flag, 1'b0);

        // down wrap from 0 also matches the all-ones compare values
        cnt_dir = 1'b1; cnt_en = 1'b1; cyc(1); cnt_en = 1'b0;
        chk("down_wrap_cnt", cnt, {64{1'b1}});
        chk("down_wrap_ovf", ovf_flag, 1'b1);
        chk("down_wrap_match", int_flag, 2'b11);
        chk("irq_masked", irq, 1'b0);
        int_clr = 2'b11; cyc(1); int_clr = 2'b00;
        chk("int_clr", int_flag, 2'b00);
        cnt_dir = 1'b0;
        clr();

        // prescaler divide by 4
        div_en = 1'b1; div_val = 8'd3; cnt_en = 1'b1;
        cyc(12);
        chk("div4_12cyc", cnt, 64'd3);
        cyc(2);
        clr();
        chk("div_after_clr", cnt, 64'd0);
        cyc(3);
        chk("div_restart_hold", cnt, 64'd0);
        cyc(1);
        chk("div_restart_tick", cnt, 64'd1);
        cnt_en = 1'b0;
        clr();
        div_val = 8'd0; cnt_en = 1'b1;
        cyc(3);
        chk("div_val0", cnt, 64'd3);
        cnt_en = 1'b0; div_en = 1'b0;
        clr();

        // compare channel 1 at 10
        wr(5'd4, 32'd10);
        wr(5'd5, 32'd0);
        chk("cmp1_written", cmp_flat[127:64], 64'd10);
        int_mask = 2'b10; cnt_en = 1'b1;
        cyc(9);
        chk("pre_match_flag", {int_flag, irq}, 3'b000);
        cyc(1);
        chk("match_cnt", cnt, 64'd10);
        chk("match_flag_irq", {int_flag, irq}, 3'b101);
        wr(5'd0, 32'd9);
        chk("wr_blocks_step", cnt, 64'd9);
        int_clr = 2'b10; cyc(1); int_clr = 2'b00;
        chk("set_beats_clr", {cnt[7:0], int_flag}, {8'd10, 2'b10});
        int_clr = 2'b10; cyc(1); int_clr = 2'b00;
        chk("clr_no_match", {int_flag, irq}, 3'b000);
        cnt_en = 1'b0;
        clr();

        // debug halt
        cnt_en = 1'b1;
        cyc(7);
        chk("halt_pre_cnt", cnt, 64'd7);
        halt_req = 1'b1;
        cyc(1);
        chk("halt_ack", halt_ack, 1'b1);
        chk("halt_inflight", cnt, 64'd8);
        cyc(2);
        chk("halt_frozen", cnt, 64'd8);
        wr(5'd0, 32'h20);
        chk("halt_write", cnt, 64'h20);
        halt_req = 1'b0;
        cyc(1);
        chk("halt_release", {halt_ack, cnt}, {1'b0, 64'h20});
        cyc(1);
        chk("resume", cnt, 64'h21);
        cnt_en = 1'b0;
        clr();

        // cmp[0] = 4, up undivided
        wr(5'd2, 32'd4);
        wr(5'd3, 32'd0);
        int_clr = 2'b11; cyc(1); int_clr = 2'b00;
`ifdef TMR_AUTORELOAD_EN
        exp_seq = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd0, 64'd1};
`else
        exp_seq = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6};
`endif
        cnt_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk($sformatf("seq_%0d", i), cnt, exp_seq[i]);
            if (i == 3) chk("cmp0_match", int_flag, 2'b01);
        end
        chk("seq_ovf", ovf_flag, 1'b0);
        cnt_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
